// File: rtl/ocl_cmd_initiator.sv
// AXI-Lite command initiator: writes a packed {op,mo,id} word to CMD_ADDR, then polls it until a result returns.
// Optional build macro OCL_CMD_POLL_BACKOFF_EN inserts POLL_GAP idle cycles between poll reads.
module ocl_cmd_initiator #(
   parameter logic [31:0] CMD_ADDR = 32'h0000_0500,
   parameter int unsigned POLL_MAX = 16,
   parameter int unsigned POLL_GAP = 4
) (
   input  logic        clk_main_a0,
   input  logic        rst_main_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic        cmd_mo,
   input  logic [27:0] cmd_id,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [2:0]  rsp_op,
   output logic        rsp_mo,
   output logic [27:0] rsp_id,
   output logic        rsp_err,
   output logic        busy,
   output logic        m_awvalid,
   output logic [31:0] m_awaddr,
   input  logic        m_awready,
   output logic        m_wvalid,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        m_wready,
   input  logic        m_bvalid,
   input  logic [1:0]  m_bresp,
   output logic        m_bready,
   output logic        m_arvalid,
   output logic [31:0] m_araddr,
   input  logic        m_arready,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   output logic        m_rready
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_WRESP, S_RD_A, S_RD_D, S_RSP, S_GAP
   } state_e;

   localparam logic [7:0] POLL_MAX_C = 8'(POLL_MAX);
`ifdef OCL_CMD_POLL_BACKOFF_EN
   localparam logic [7:0] GAP_LOAD = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);
`endif

   state_e      state_q, state_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  poll_cnt_q, poll_cnt_d;
   logic [2:0]  rsp_op_q, rsp_op_d;
   logic        rsp_mo_q, rsp_mo_d;
   logic [27:0] rsp_id_q, rsp_id_d;
   logic        rsp_err_q, rsp_err_d;
`ifdef OCL_CMD_POLL_BACKOFF_EN
   logic [7:0]  gap_cnt_q, gap_cnt_d;
`endif

   logic accept, aw_hs, w_hs, aw_ok, w_ok, rd_final;

   assign accept   = cmd_valid && cmd_ready_q;
   assign aw_hs    = awvalid_q && m_awready;
   assign w_hs     = wvalid_q && m_wready;
   assign aw_ok    = aw_done_q || aw_hs;
   assign w_ok     = w_done_q || w_hs;
   // A read ends polling on a bus error, a real result, or an exhausted poll budget.
   assign rd_final = (m_rresp != 2'b00) || (m_rdata[31:29] != 3'b111) ||
                     (poll_cnt_q == POLL_MAX_C);

   // NOTE: async reset clears every state flop so an abort mid-transaction leaves no residue.
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) state_q <= S_IDLE;
      else             state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_WR;
         S_WR:    if (aw_ok && w_ok) state_d = S_WRESP;
         S_WRESP: if (m_bvalid) state_d = (m_bresp != 2'b00) ? S_RSP : S_RD_A;
         S_RD_A:  if (m_arready) state_d = S_RD_D;
`ifdef OCL_CMD_POLL_BACKOFF_EN
         S_RD_D:  if (m_rvalid) state_d = rd_final ? S_RSP : S_GAP;
         S_GAP:   if (gap_cnt_q == 8'd0) state_d = S_RD_A;
`else
         S_RD_D:  if (m_rvalid) state_d = rd_final ? S_RSP : S_RD_A;
`endif
         S_RSP:   if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      m_bready  = (state_q == S_WRESP);
      m_arvalid = (state_q == S_RD_A);
      m_rready  = (state_q == S_RD_D);
      rsp_valid = (state_q == S_RSP);
      busy      = (state_q != S_IDLE);
   end

   always_comb begin
      cmd_ready_d = (state_d == S_IDLE);
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      wdata_d     = wdata_q;
      poll_cnt_d  = poll_cnt_q;
      rsp_op_d    = rsp_op_q;
      rsp_mo_d    = rsp_mo_q;
      rsp_id_d    = rsp_id_q;
      rsp_err_d   = rsp_err_q;
`ifdef OCL_CMD_POLL_BACKOFF_EN
      gap_cnt_d   = gap_cnt_q;
`endif
      unique case (state_q)
         S_IDLE: if (accept) begin
            wdata_d   = {cmd_op, cmd_mo, cmd_id};
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
         end
         S_WR: begin
            if (aw_hs) begin awvalid_d = 1'b0; aw_done_d = 1'b1; end
            if (w_hs)  begin wvalid_d  = 1'b0; w_done_d  = 1'b1; end
            if (aw_ok && w_ok) begin aw_done_d = 1'b0; w_done_d = 1'b0; end
         end
         S_WRESP: if (m_bvalid) begin
            if (m_bresp != 2'b00) begin
               rsp_err_d = 1'b1; rsp_op_d = '0; rsp_mo_d = 1'b0; rsp_id_d = '0;
            end else begin
               poll_cnt_d = 8'd0;
            end
         end
         S_RD_A: if (m_arready && poll_cnt_q != 8'hFF) poll_cnt_d = poll_cnt_q + 8'd1;
         S_RD_D: if (m_rvalid) begin
            if (m_rresp != 2'b00 || m_rdata[31:29] == 3'b111) begin
               // Bus error or timeout; a plain non-final poll is overwritten by the next read.
               rsp_err_d = 1'b1; rsp_op_d = '0; rsp_mo_d = 1'b0; rsp_id_d = '0;
            end else begin
               rsp_err_d = 1'b0;
               rsp_op_d  = m_rdata[31:29];
               rsp_mo_d  = m_rdata[28];
               rsp_id_d  = m_rdata[27:0];
            end
`ifdef OCL_CMD_POLL_BACKOFF_EN
            gap_cnt_d = GAP_LOAD;
`endif
         end
`ifdef OCL_CMD_POLL_BACKOFF_EN
         S_GAP: if (gap_cnt_q != 8'd0) gap_cnt_d = gap_cnt_q - 8'd1;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         wdata_q     <= '0;
         poll_cnt_q  <= '0;
         rsp_op_q    <= '0;
         rsp_mo_q    <= 1'b0;
         rsp_id_q    <= '0;
         rsp_err_q   <= 1'b0;
`ifdef OCL_CMD_POLL_BACKOFF_EN
         gap_cnt_q   <= '0;
`endif
      end else begin
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         wdata_q     <= wdata_d;
         poll_cnt_q  <= poll_cnt_d;
         rsp_op_q    <= rsp_op_d;
         rsp_mo_q    <= rsp_mo_d;
         rsp_id_q    <= rsp_id_d;
         rsp_err_q   <= rsp_err_d;
`ifdef OCL_CMD_POLL_BACKOFF_EN
         gap_cnt_q   <= gap_cnt_d;
`endif
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign m_awvalid = awvalid_q;
   assign m_wvalid  = wvalid_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = 4'hF;
   assign m_awaddr  = CMD_ADDR;
   assign m_araddr  = CMD_ADDR;
   assign rsp_op    = rsp_op_q;
   assign rsp_mo    = rsp_mo_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_err   = rsp_err_q;

endmodule
